// File: rtl/count_seq_ctrl.sv
// Run sequencer for an 8-bit up/down counter with load: loads a start value, lets it
// run to a stop value, then holds it. Optional macro COUNT_SEQ_STEP_EN adds a step gate.
module count_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_stop,
  input  logic             cmd_up,
  input  logic             abort,
`ifdef COUNT_SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic [WIDTH-1:0] ctr_count,
  output logic             ctr_load,
  output logic             ctr_up,
  output logic [WIDTH-1:0] ctr_data,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] stop_val;
  logic             dir;
  logic             aborted_q;
  logic             step_ok;
  logic             at_stop;

`ifdef COUNT_SEQ_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign at_stop = (ctr_count == stop_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stop_val  <= '0;
      dir       <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            start_val <= cmd_start;
            stop_val  <= cmd_stop;
            dir       <= cmd_up;
            aborted_q <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          // The load completes regardless; an abort here only skips the run.
          if (abort) begin
            aborted_q <= 1'b1;
            state     <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (at_stop) begin
            aborted_q <= 1'b0;
            state     <= DONE;
          end else if (abort) begin
            aborted_q <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The counter has no enable: every hold reloads it with its own count.
  always_comb begin
    ctr_load  = 1'b1;
    ctr_data  = ctr_count;
    ctr_up    = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: cmd_ready = 1'b1;
      LOAD: begin
        busy     = 1'b1;
        ctr_data = start_val;
      end
      RUN: begin
        busy   = 1'b1;
        ctr_up = dir;
        if (!at_stop && !abort && step_ok) ctr_load = 1'b0;
      end
      default: ;
    endcase
    if (rst) begin
      ctr_load  = 1'b1;
      ctr_data  = ctr_count;
      cmd_ready = 1'b0;
    end
  end

  assign done    = (state == DONE);
  assign aborted = (state == DONE) & aborted_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl, closing the loop through a model of the
// up/down counter with load.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_start = 8'h00;
  logic [7:0] cmd_stop = 8'h00;
  logic       cmd_up = 1'b0;
  logic       abort = 1'b0;
`ifdef COUNT_SEQ_STEP_EN
  logic       step = 1'b1;
`endif
  logic [7:0] cnt = 8'h37;
  logic       ctr_load;
  logic       ctr_up;
  logic [7:0] ctr_data;
  logic       busy;
  logic       done;
  logic       aborted;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int n;
  int snap;
  logic [7:0] seq[$];
  logic [7:0] exp_down [7];

  count_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_up(cmd_up),
    .abort(abort),
`ifdef COUNT_SEQ_STEP_EN
    .step(step),
`endif
    .ctr_count(cnt), .ctr_load(ctr_load), .ctr_up(ctr_up), .ctr_data(ctr_data),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Controlled counter: load wins, otherwise step by one in ctr_up direction.
  always @(posedge clk) begin
    if (ctr_load) cnt <= ctr_data;
    else if (ctr_up) cnt <= cnt + 8'd1;
    else cnt <= cnt - 8'd1;
  end

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] s, input logic [7:0] e, input logic u);
    cmd_start = s;
    cmd_stop  = e;
    cmd_up    = u;
    cmd_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    chk("issue_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // From LOAD: counts RUN cycles until done, recording the count seen in each.
  task automatic run_to_done(output int cycles);
    cycles = 0;
    seq.delete();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done) break;
      seq.push_back(cnt);
      cycles++;
    end
    chk("run_done_reached", done, 1'b1);
  endtask

  initial begin
    exp_down[0] = 8'h03; exp_down[1] = 8'h02; exp_down[2] = 8'h01; exp_down[3] = 8'h00;
    exp_down[4] = 8'hFF; exp_down[5] = 8'hFE; exp_down[6] = 8'hFD;

    // Reset with the counter sitting at 0x37
    #1;
    chk("rst_load", ctr_load, 1'b1);
    chk("rst_data", ctr_data, 8'h37);
    tick();
    tick();
    chk("rst_cnt_held", cnt, 8'h37);
    rst = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hold", ctr_load, 1'b1);

    // Up run 0x10 -> 0x15
    issue(8'h10, 8'h15, 1'b1);
    chk("up_load_busy", busy, 1'b1);
    chk("up_load_data", ctr_data, 8'h10);
    chk("up_load_ready", cmd_ready, 1'b0);
    run_to_done(n);
    chk("up_run_cycles", n, 6);
    chk("up_first", seq[0], 8'h10);
    chk("up_last", seq[5], 8'h15);
    chk("up_aborted", aborted, 1'b0);
    chk("up_done_cnt", cnt, 8'h15);
    tick();
    chk("up_done_pulse", done, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("up_idle_hold", cnt, 8'h15);
    chk("up_done_seen", done_seen, 1);

    // Down run with wrap 0x03 -> 0xFD
    issue(8'h03, 8'hFD, 1'b0);
    run_to_done(n);
    chk("dn_run_cycles", n, 7);
    for (int i = 0; i < 7; i++) chk("dn_seq", seq[i], exp_down[i]);
    chk("dn_aborted", aborted, 1'b0);
    chk("dn_cnt", cnt, 8'hFD);
    tick();

    // Degenerate start == stop
    issue(8'hA5, 8'hA5, 1'b1);
    run_to_done(n);
    chk("deg_run_cycles", n, 1);
    chk("deg_cnt", cnt, 8'hA5);
    tick();
    tick();
    chk("deg_hold", cnt, 8'hA5);

    // Abort on the 5th RUN cycle
    issue(8'h00, 8'h80, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("ab_cnt5", cnt, 8'h04);
    abort = 1'b1;
    #1;
    chk("ab_hold_load", ctr_load, 1'b1);
    chk("ab_hold_data", ctr_data, 8'h04);
    tick();
    abort = 1'b0;
    chk("ab_done", done, 1'b1);
    chk("ab_aborted", aborted, 1'b1);
    chk("ab_cnt", cnt, 8'h04);
    tick();
    chk("ab_frozen", cnt, 8'h04);

    // Abort coincident with the stop match: stop wins
    issue(8'h40, 8'h42, 1'b1);
    tick();
    tick();
    tick();
    chk("abs_at_stop", cnt, 8'h42);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abs_done", done, 1'b1);
    chk("abs_aborted", aborted, 1'b0);
    chk("abs_cnt", cnt, 8'h42);
    tick();

    // cmd_valid held high continuously
    cmd_start = 8'h50;
    cmd_stop  = 8'h51;
    cmd_up    = 1'b1;
    cmd_valid = 1'b1;
    #1;
    chk("hs_ready_idle", cmd_ready, 1'b1);
    tick();
    chk("hs_ready_load", cmd_ready, 1'b0);
    tick();
    chk("hs_ready_run1", cmd_ready, 1'b0);
    tick();
    chk("hs_ready_run2", cmd_ready, 1'b0);
    tick();
    chk("hs_done", done, 1'b1);
    chk("hs_ready_done", cmd_ready, 1'b0);
    tick();
    chk("hs_ready_idle2", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("hs_2nd_load", busy, 1'b1);
    chk("hs_2nd_data", ctr_data, 8'h50);
    run_to_done(n);
    chk("hs_2nd_cycles", n, 2);
    tick();
    chk("hs_done_seen", done_seen, 7);

    // Reset mid-run at count 0x22
    issue(8'h20, 8'h80, 1'b1);
    tick();
    tick();
    tick();
    chk("mr_cnt", cnt, 8'h22);
    snap = done_seen;
    rst = 1'b1;
    #1;
    chk("mr_load", ctr_load, 1'b1);
    chk("mr_data", ctr_data, 8'h22);
    tick();
    chk("mr_frozen", cnt, 8'h22);
    rst = 1'b0;
    #1;
    chk("mr_idle_ready", cmd_ready, 1'b1);
    chk("mr_idle_busy", busy, 1'b0);
    tick();
    chk("mr_still", cnt, 8'h22);
    chk("mr_no_done", done_seen, snap);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
